// File: rtl/fetch_sequencer.sv
// fetch_sequencer: reads an opcode and its operand bytes over a req/ack
// memory handshake and drives the address register block's strobes.
// Each memory access has a wait-state timeout that aborts the fetch and
// raises a sticky fault flag.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start, sel=1, no strobes
// OPC   | read opcode byte at PC
// DEC   | decode opcode class (opcode[7:6])
// IMM   | read one immediate byte into operand
// LO    | read low address byte into temp low register
// HI    | read high address byte into temp high register
// XFER  | move temp registers into AR (class 10) or PC (class 11)
// DONE  | one-cycle completion pulse
module fetch_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       memAck,
  input  logic [7:0] memData,
  output logic       memReq,
  output logic       sel,
  output logic       pcInc,
  output logic       pcLoad,
  output logic       arLoad,
  output logic       tlLoad,
  output logic       thLoad,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, OPC, DEC, IMM, LO, HI, XFER, DONE
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             memState;
  logic             timeoutHit;
  logic [1:0]       opClass;

  assign opClass    = opcode[7:6];
  assign memState   = (state == OPC) || (state == IMM) || (state == LO) || (state == HI);
  assign timeoutHit = memState && !memAck && (waitCnt == CNT_W'(TIMEOUT));
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic and combinational strobes
  always_comb begin
    stateNext = state;
    memReq    = 1'b0;
    sel       = 1'b1;
    pcInc     = 1'b0;
    pcLoad    = 1'b0;
    arLoad    = 1'b0;
    tlLoad    = 1'b0;
    thLoad    = 1'b0;
    done      = 1'b0;

    // Every memory state shares request, PC increment on ack, and abort
    if (memState) begin
      memReq = 1'b1;
      if (memAck)          pcInc     = 1'b1;
      else if (timeoutHit) stateNext = IDLE;
    end

    case (state)
      IDLE: if (start) stateNext = OPC;
      OPC:  if (memAck) stateNext = DEC;
      DEC: begin
        case (opClass)
          2'b00:   stateNext = DONE;
          2'b01:   stateNext = IMM;
          default: stateNext = LO;
        endcase
      end
      IMM:  if (memAck) stateNext = DONE;
      LO: begin
        if (memAck) begin
          tlLoad    = 1'b1;
          stateNext = HI;
        end
      end
      HI: begin
        if (memAck) begin
          thLoad    = 1'b1;
          stateNext = XFER;
        end
      end
      XFER: begin
        sel = 1'b0;
        // Only classes 10 and 11 reach XFER, so bit 0 picks AR vs PC
        if (opClass[0]) pcLoad = 1'b1;
        else            arLoad = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Wait-state counter: counts unacknowledged cycles, zero on entry to a memory state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                    waitCnt <= '0;
    else if (memState && !memAck && !timeoutHit)   waitCnt <= waitCnt + CNT_W'(1);
    else                                           waitCnt <= '0;
  end

  // Opcode and immediate capture on the acknowledging edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      opcode  <= 8'h00;
      operand <= 8'h00;
    end else begin
      if (state == OPC && memAck) opcode  <= memData;
      if (state == IMM && memAck) operand <= memData;
    end
  end

  // Sticky timeout flag, cleared when a new fetch is accepted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       fault <= 1'b0;
    else if (timeoutHit)              fault <= 1'b1;
    else if (state == IDLE && start)  fault <= 1'b0;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that drives the address register block's control strobes (pcInc, pcLoad, arLoad, tlLoad, thLoad, sel) while reading an opcode and its operand bytes from memory over a request/acknowledge handshake. It sits between the CPU control unit (start/done) and the memory port. It captures the opcode and an 8-bit immediate locally. It steers 16-bit little-endian operands into the address register block's temp registers, then transfers them to AR or PC. Includes a per-access wait-state timeout.

## Interface
- TIMEOUT, 15: max cycles memReq may stay unacknowledged before abort (1..255).
- clk  in  1  clock; all state changes on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin fetch; sampled only in IDLE.
- memAck  in  1  memory accepted request; memData valid this cycle.
- memData  in  8  read data (same bus as the address register block's data input).
- memReq  out  1  read request at address on PC (sel=1).
- sel  out  1  address-mux select; 1 = PC, 0 = temp registers.
- pcInc, pcLoad, arLoad, tlLoad, thLoad  out  1 each  strobes to the address register block.
- opcode  out  8  last fetched opcode.
- operand  out  8  last fetched 1-byte immediate.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, fetch complete.
- fault  out  1  sticky timeout flag.

## Operation
- Opcode class = opcode[7:6]: 00 no operand; 01 one immediate byte; 10 two-byte address -> AR; 11 two-byte target -> PC.
- States: IDLE, OPC, DEC, IMM, LO, HI, XFER, DONE.
- IDLE: all strobes 0, sel=1. start=1 -> OPC, clear fault, clear wait counter.
- OPC/IMM/LO/HI (memory states): memReq=1, sel=1. On the memAck cycle: pcInc=1 (combinational, same cycle), and:
  - OPC: opcode<=memData; -> DEC.
  - IMM: operand<=memData; -> DONE.
  - LO: tlLoad=1; -> HI.
  - HI: thLoad=1; -> XFER.
- DEC (1 cycle, no strobes): class 00 -> DONE; 01 -> IMM; 10/11 -> LO.
- XFER (1 cycle): sel=0. Class 10: arLoad=1. Class 11: pcLoad=1. -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- pcInc and pcLoad are never high together; arInc is not driven by this block.
- Wait counter: width ceil(log2(TIMEOUT+1)); cleared on entry to each memory state; increments each memory-state cycle with memAck=0. At count==TIMEOUT with memAck=0: fault<=1, -> IDLE, no strobes issued. memAck on the same cycle takes priority and the access completes normally.
- start while busy: ignored. start in the DONE cycle: ignored; a new fetch requires start in IDLE.
- Reset (any state): -> IDLE. opcode=0, operand=0, fault=0, counter=0. All outputs are low except sel=1.

## Timing
- Strobes (memReq, pcInc, tl/thLoad, arLoad, pcLoad, sel, done) are combinational from state and memAck. The address register block samples them on the same edge that advances the state.
- opcode and operand update at the memAck edge; they are valid from the next cycle.
- Zero-wait latency, counted from the start edge to done high: class 00 = 3 cycles (OPC, DEC, DONE); class 01 = 4; class 10/11 = 6 (OPC, DEC, LO, HI, XFER, DONE).
- Each wait cycle before memAck adds exactly one cycle.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- Timeout path: memReq stays high for TIMEOUT+1 cycles (counts 0..TIMEOUT). fault rises the next cycle and busy falls with it.

## Test plan
- Class 00, memAck tied high, memData=0x05 -> opcode=0x05, one pcInc, done 3 cycles after start, no tl/thLoad.
- Class 01, bytes 0x41,0x7E, 2 wait cycles on the second byte -> operand=0x7E, two pcInc pulses, done 6 cycles after start.
- Class 10, bytes 0x80,0x34,0x12, with a real address register block attached and PC=0x0100 -> AR=0x1234, PC=0x0103, arLoad with sel=0 in XFER.
- Class 11, bytes 0xC0,0xCD,0xAB -> PC=0xABCD after XFER, pcInc never coincides with pcLoad.
- memAck held low in LO, TIMEOUT=15 -> fault=1 after 16 request cycles, FSM in IDLE, no tlLoad; the next start clears fault.
- n_rst pulsed low during HI -> immediate IDLE, all strobes 0, opcode=0; start pulses while busy produce no second fetch.
